phaser_symbol_scheduler: RTL and testbench

//  Sequences the 4-phase backscatter modulator. Buffers payload bytes from the host logic,

---
 rtl/phaser_symbol_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_phaser_symbol_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/phaser_symbol_scheduler.sv
// Byte FIFO + symbol sequencer driving the 4-phase backscatter modulator.
// Optional preamble state is compiled in with `define PHASER_PREAMBLE_EN.
module phaser_symbol_scheduler #(
  parameter int unsigned SYMBOL_CYCLES    = 16,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned PREAMBLE_SYMBOLS = 8,
  parameter int unsigned LEN_W            = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             trigger_signal,
  output logic [1:0]       state_input,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW =
    (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYMBOL_CYCLES - 1);
`ifdef PHASER_PREAMBLE_EN
  localparam int unsigned PW =
    (PREAMBLE_SYMBOLS > 1) ? $clog2(PREAMBLE_SYMBOLS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_SYMBOLS - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef PHASER_PREAMBLE_EN
    S_PRE  = 2'd2,
`endif
    S_PAY  = 2'd1
  } state_t;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             r_rdy;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_sym;
  logic [7:0]       r_byte;
  logic [LEN_W-1:0] r_left;
  logic             r_done;
  logic             r_und;
`ifdef PHASER_PREAMBLE_EN
  logic [PW-1:0]    r_pre;
  logic [PW-1:0]    w_pre_n;
`endif

  logic [AW:0]      w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_head;
  logic             w_sym_end;
  logic             w_bnd;
  logic [LEN_W-1:0] w_bnd_left;
  state_t           w_state_n;
  logic [CW-1:0]    w_cnt_n;
  logic [1:0]       w_sym_n;
  logic [7:0]       w_byte_n;
  logic [LEN_W-1:0] w_left_n;
  logic             w_done_n;
  logic             w_und_n;

  assign w_count   = r_wp - r_rp;
  assign w_full    = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_wp == r_rp);
  assign w_push    = data_valid && data_ready;
  assign w_head    = r_mem[r_rp[AW-1:0]];
  assign w_sym_end = (r_cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wp[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // r_left counts bytes still to fetch after the one being sent
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_sym_n    = r_sym;
    w_byte_n   = r_byte;
    w_left_n   = r_left;
    w_done_n   = 1'b0;
    w_und_n    = 1'b0;
    w_pop      = 1'b0;
    w_bnd      = 1'b0;
    w_bnd_left = r_left;
`ifdef PHASER_PREAMBLE_EN
    w_pre_n    = r_pre;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (pkt_len == '0) begin
            w_done_n = 1'b1;
          end else begin
            w_cnt_n = '0;
`ifdef PHASER_PREAMBLE_EN
            w_state_n = S_PRE;
            w_pre_n   = '0;
            w_left_n  = pkt_len;
`else
            w_bnd      = 1'b1;
            w_bnd_left = pkt_len;
`endif
          end
        end
      end
`ifdef PHASER_PREAMBLE_EN
      S_PRE: begin
        if (w_sym_end) begin
          w_cnt_n = '0;
          if (r_pre == PRE_LAST) begin
            w_bnd = 1'b1;
          end else begin
            w_pre_n = r_pre + 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
`endif
      S_PAY: begin
        if (w_sym_end) begin
          w_cnt_n = '0;
          if (r_sym == 2'd3) begin
            if (r_left == '0) begin
              w_done_n  = 1'b1;
              w_state_n = S_IDLE;
            end else begin
              w_bnd = 1'b1;
            end
          end else begin
            w_sym_n  = r_sym + 1'b1;
            w_byte_n = {r_byte[5:0], 2'b00};
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_bnd) begin
      if (w_empty) begin
        w_und_n   = 1'b1;
        w_state_n = S_IDLE;
      end else begin
        w_pop     = 1'b1;
        w_byte_n  = w_head;
        w_sym_n   = 2'd0;
        w_left_n  = w_bnd_left - 1'b1;
        w_state_n = S_PAY;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sym   <= '0;
      r_byte  <= '0;
      r_left  <= '0;
      r_done  <= 1'b0;
      r_und   <= 1'b0;
`ifdef PHASER_PREAMBLE_EN
      r_pre   <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_sym   <= w_sym_n;
      r_byte  <= w_byte_n;
      r_left  <= w_left_n;
      r_done  <= w_done_n;
      r_und   <= w_und_n;
`ifdef PHASER_PREAMBLE_EN
      r_pre   <= w_pre_n;
`endif
    end
  end

  always_comb begin
    state_input = 2'd0;
    if (r_state == S_PAY) begin
      state_input = r_byte[7:6];
    end
`ifdef PHASER_PREAMBLE_EN
    if (r_state == S_PRE) begin
      state_input = {r_pre[0], 1'b0};
    end
`endif
  end

  assign trigger_signal = (r_state != S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign underrun       = r_und;
  assign data_ready     = r_rdy && !w_full;

endmodule

// File: tb/tb_phaser_symbol_scheduler.sv
// Bench for phaser_symbol_scheduler: directed table, corner sequences,
// and random traffic against a time-indexed packet model.
module tb_phaser_symbol_scheduler;

  localparam int SC  = 4;
  localparam int DEP = 4;
`ifdef PHASER_PREAMBLE_EN
  localparam int PRE = 8;
`else
  localparam int PRE = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pkt_len = '0;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       trigger_signal;
  logic [1:0] state_input;
  logic       busy;
  logic       done;
  logic       underrun;

  phaser_symbol_scheduler #(
    .SYMBOL_CYCLES(SC),
    .FIFO_DEPTH(DEP),
    .PREAMBLE_SYMBOLS(8),
    .LEN_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .pkt_len(pkt_len),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .trigger_signal(trigger_signal),
    .state_input(state_input),
    .busy(busy),
    .done(done),
    .underrun(underrun)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int unsigned cyc = 0;

  // reference model: packet position as a cycle index since start
  logic [7:0] m_q[$];
  bit         m_valid = 0;
  bit         m_act = 0;
  int         m_t, m_len, m_p, m_r;
  logic [7:0] m_cur = '0;
  logic       e_trig = 0, e_busy = 0, e_done = 0, e_und = 0, e_rdy = 0;
  logic [1:0] e_sym = 0;

  initial forever begin
    @(posedge clock);
    cyc++;
    if (!reset) begin
      m_q.delete();
      m_act = 0; e_done = 0; e_und = 0; e_rdy = 0;
      e_trig = 0; e_busy = 0; e_sym = 0;
      m_valid = 1;
    end else begin
      e_done = 0; e_und = 0;
      if (m_act) begin
        m_t++;
      end else if (start) begin
        if (pkt_len == 0) e_done = 1;
        else begin m_act = 1; m_len = pkt_len; m_t = 1; end
      end
      if (m_act) begin
        if (m_t <= PRE*SC) begin
          e_sym = (((m_t-1)/SC) % 2 == 1) ? 2'd2 : 2'd0;
        end else begin
          m_p = m_t - 1 - PRE*SC;
          if (m_p == 4*SC*m_len) begin
            e_done = 1; m_act = 0;
          end else begin
            m_r = m_p % (4*SC);
            if (m_r == 0) begin
              if (m_q.size() == 0) begin e_und = 1; m_act = 0; end
              else m_cur = m_q.pop_front();
            end
            if (m_act) e_sym = 2'((m_cur >> (6 - 2*(m_r/SC))) & 8'h3);
          end
        end
      end
      if (data_valid && e_rdy) m_q.push_back(data_in);
      e_rdy = (m_q.size() < DEP);
      e_trig = m_act; e_busy = m_act;
      if (!m_act) e_sym = 0;
    end
  end

  initial forever begin
    @(negedge clock);
    if (m_valid) begin
      n_chk++;
      if ({trigger_signal, state_input, busy, done, underrun, data_ready} !==
          {e_trig, e_sym, e_busy, e_done, e_und, e_rdy}) begin
        n_err++;
        $display("FAIL model_cycle t=%0t got trg=%b sym=%0d bsy=%b dn=%b ur=%b rdy=%b exp trg=%b sym=%0d bsy=%b dn=%b ur=%b rdy=%b",
          $time, trigger_signal, state_input, busy, done, underrun, data_ready,
          e_trig, e_sym, e_busy, e_done, e_und, e_rdy);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    data_in = b;
    data_valid = 1'b1;
    while (!data_ready && n < 200) begin @(negedge clock); n++; end
    if (!data_ready) chk("push_timeout", 0, 1);
    @(negedge clock);
  endtask

  task automatic start_pkt(input int l, output int s);
    start = 1'b1;
    pkt_len = 8'(l);
    s = int'(cyc);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_end(input int s, output int k, output bit u);
    int n = 0;
    while (!(done || underrun) && n < 3000) begin @(negedge clock); n++; end
    if (n >= 3000) chk("end_timeout", 0, 1);
    k = int'(cyc) - s;
    u = underrun;
  endtask

  typedef struct {
    int          n;
    logic [31:0] d;
    int          len;
    int          cyc;
    bit          und;
  } vec_t;

  vec_t vt[6];
  int s, k;
  bit u;
  logic [31:0] bytes;

  initial begin
    vt[0] = '{1, 32'hB4000000, 1, SC*(4+PRE)+1,  1'b0};
    vt[1] = '{2, 32'h1BE40000, 2, SC*(8+PRE)+1,  1'b0};
    vt[2] = '{1, 32'h5A000000, 2, SC*(4+PRE)+1,  1'b1};
    vt[3] = '{0, 32'h00000000, 1, SC*PRE+1,      1'b1};
    vt[4] = '{4, 32'hC3963C69, 4, SC*(16+PRE)+1, 1'b0};
    vt[5] = '{0, 32'h00000000, 0, 1,             1'b0};

    repeat (3) @(negedge clock);
    chk("reset_outputs",
        {trigger_signal, state_input, busy, done, underrun, data_ready}, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", data_ready, 1);

    for (int i = 0; i < 6; i++) begin
      bytes = vt[i].d;
      for (int j = 0; j < vt[i].n; j++) push(bytes[31-8*j -: 8]);
      data_valid = 1'b0;
      start_pkt(vt[i].len, s);
      wait_end(s, k, u);
      chk($sformatf("vec%0d_end_cycle", i), k, vt[i].cyc);
      chk($sformatf("vec%0d_underrun", i), u, vt[i].und);
      chk($sformatf("vec%0d_trig_off", i), trigger_signal, 0);
      repeat (2) @(negedge clock);
    end

    // backpressure: fifth byte waits for the first pop
    for (int j = 0; j < 4; j++) push(8'h10 + 8'(j));
    data_in = 8'h99;
    data_valid = 1'b1;
    @(negedge clock);
    chk("full_not_ready", data_ready, 0);
    start_pkt(4, s);
    push(8'h99);
    data_valid = 1'b0;
    start = 1'b1; pkt_len = 8'd2;
    @(negedge clock);
    start = 1'b0;
    wait_end(s, k, u);
    chk("bp_end_cycle", k, SC*(16+PRE)+1);
    chk("bp_underrun", u, 0);
    @(negedge clock);
    chk("after_done_idle", busy, 0);

    start_pkt(0, s);
    chk("len0_done", done, 1);
    chk("len0_trig", trigger_signal, 0);
    @(negedge clock);
    chk("len0_single_pulse", done, 0);

    // abort a packet (uses leftover 0x99) with reset
    start_pkt(1, s);
    repeat (6) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("abort_quiet", {trigger_signal, busy, done, underrun, data_ready}, 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 3000; i++) begin
      data_valid = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      start = ($urandom_range(0, 39) == 0);
      pkt_len = 8'($urandom_range(0, 5));
      @(negedge clock);
    end
    data_valid = 1'b0;
    start = 1'b0;
    repeat (4) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
